// File: rtl/wb_queue.sv
// ============================================================================
// Module      : wb_queue
// Description : Register-file write-back queue for load/multi-cycle results.
//               Main-pipeline writes take the write port first, and queued
//               entries are snooped for read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_addr,
    input  logic [31:0]              in_data,
    input  logic                     pipe_wen,
    input  logic [4:0]               pipe_addr,
    input  logic [31:0]              pipe_data,
    output logic                     w_en,
    output logic [4:0]               w_addr,
    output logic [31:0]              w_din,
    input  logic [4:0]               r1_addr,
    input  logic [4:0]               r2_addr,
    input  logic [4:0]               r3_addr,
    output logic                     r1_hit,
    output logic                     r2_hit,
    output logic                     r3_hit,
    output logic [31:0]              r1_fwd,
    output logic [31:0]              r2_fwd,
    output logic [31:0]              r3_fwd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] live_q;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic pipe_act;
    logic pop;
    logic enq;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        count    = count_q;
        in_ready = !rst && !full;
        pipe_act = !rst && pipe_wen && (pipe_addr != 5'd0);
        pop      = !rst && !pipe_act && !empty;
        enq      = in_valid && in_ready && (in_addr != 5'd0);

        head_d   = pop ? head_q + AW'(1) : head_q;
        tail_d   = enq ? tail_q + AW'(1) : tail_q;
        count_d  = count_q + CW'(enq) - CW'(pop);

        if (pipe_act) begin
            w_en   = 1'b1;
            w_addr = pipe_addr;
            w_din  = pipe_data;
        end else if (pop) begin
            w_en   = live_q[head_q];
            w_addr = addr_q[head_q];
            w_din  = data_q[head_q];
        end else begin
            w_en   = 1'b0;
            w_addr = 5'd0;
            w_din  = 32'd0;
        end
    end

    // live is kept clear on free slots, so live alone marks a pending write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_act && (addr_q[i] == pipe_addr)) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                live_q[head_q] <= 1'b0;
            end
            // Enqueue comes last so a same-cycle pipe write cannot kill it
            if (enq) begin
                live_q[tail_q] <= 1'b1;
                addr_q[tail_q] <= in_addr;
                data_q[tail_q] <= in_data;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    logic [4:0] rd_addr [3];
    assign rd_addr[0] = r1_addr;
    assign rd_addr[1] = r2_addr;
    assign rd_addr[2] = r3_addr;

    generate
        for (genvar p = 0; p < 3; p++) begin : g_rd
            logic        hit;
            logic [31:0] fwd;
            // Scan oldest to youngest so the youngest match wins
            always_comb begin
                logic [AW-1:0] idx;
                hit = 1'b0;
                fwd = 32'd0;
                idx = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    idx = head_q + AW'(k);
                    if (live_q[idx] && (addr_q[idx] == rd_addr[p]) &&
                        (rd_addr[p] != 5'd0)) begin
                        hit = 1'b1;
                        fwd = data_q[idx];
                    end
                end
            end
        end
    endgenerate

    assign r1_hit = g_rd[0].hit;
    assign r2_hit = g_rd[1].hit;
    assign r3_hit = g_rd[2].hit;
    assign r1_fwd = g_rd[0].fwd;
    assign r2_fwd = g_rd[1].fwd;
    assign r3_fwd = g_rd[2].fwd;

endmodule

`default_nettype wire

// File: tb/tb_wb_queue.sv
// ============================================================================
// Module      : tb_wb_queue
// Description : Self-checking bench for wb_queue against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        pipe_wen;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_din;
    logic [4:0]  r1_addr, r2_addr, r3_addr;
    logic        r1_hit, r2_hit, r3_hit;
    logic [31:0] r1_fwd, r2_fwd, r3_fwd;
    logic [2:0]  count;
    logic        empty, full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t mq[$];

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .pipe_wen(pipe_wen), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .w_en(w_en), .w_addr(w_addr), .w_din(w_din),
        .r1_addr(r1_addr), .r2_addr(r2_addr), .r3_addr(r3_addr),
        .r1_hit(r1_hit), .r2_hit(r2_hit), .r3_hit(r3_hit),
        .r1_fwd(r1_fwd), .r2_fwd(r2_fwd), .r3_fwd(r3_fwd),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    function automatic void lookup(input logic [4:0] ra, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        if (ra != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].a == ra) begin
                    h = 1'b1;
                    d = mq[i].d;
                end
            end
        end
    endfunction

    // Apply the effect of the coming clock edge to the model
    task automatic advance();
        int n;
        bit pa;
        ent_t e;
        n  = mq.size();
        pa = pipe_wen && (pipe_addr != 5'd0);
        if (!pa && n > 0) void'(mq.pop_front());
        if (pa) foreach (mq[i]) if (mq[i].a == pipe_addr) mq[i].live = 1'b0;
        if (in_valid && n < DEPTH && in_addr != 5'd0) begin
            e.a = in_addr;
            e.d = in_data;
            e.live = 1'b1;
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] a, input logic [31:0] d);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic set_pipe(input logic w, input logic [4:0] a, input logic [31:0] d);
        pipe_wen  = w;
        pipe_addr = a;
        pipe_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 5'd4, 32'h1234);
        set_pipe(1'b1, 5'd3, 32'h55);
        r1_addr = 5'd3;
        @(posedge clk);
        #2;
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en got %0h want 0", w_en); end
        checks++; if (w_addr !== 5'd0 || w_din !== 32'd0) begin errors++; $display("FAIL reset_w_bus got %0h/%0h want 0/0", w_addr, w_din); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0h want 0", in_ready); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL reset_status got e%0h f%0h c%0d want e1 f0 c0", empty, full, count); end
        checks++; if (r1_hit !== 1'b0 || r1_fwd !== 32'd0) begin errors++; $display("FAIL reset_fwd got %0h/%0h want 0/0", r1_hit, r1_fwd); end
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        r1_addr = 5'd0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0h want 1", in_ready); end
    endtask

    task automatic test_fill_drain();
        // No pass-through: the first write appears one cycle after enqueue
        set_in(1'b1, 5'd9, 32'h99);
        #1;
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL latency_same got %0h want 0", w_en); end
        tick();
        set_in(1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (w_en !== 1'b1 || w_addr !== 5'd9 || w_din !== 32'h99) begin errors++; $display("FAIL latency_next got %0h/%0h/%0h want 1/9/99", w_en, w_addr, w_din); end
        tick();
        // Hold the write port with an unrelated pipe write so the queue fills
        set_pipe(1'b1, 5'd31, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 5'(i), 32'(i * 32'h11));
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %0h want 1", i, in_ready); end
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL fill_full got f%0h r%0h c%0d want f1 r0 c4", full, in_ready, count); end
        set_pipe(1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (w_en !== 1'b1 || w_addr !== 5'(i) || w_din !== 32'(i * 32'h11)) begin errors++; $display("FAIL drain%0d got %0h/%0h/%0h want 1/%0h/%0h", i, w_en, w_addr, w_din, i, i * 32'h11); end
            tick();
        end
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL drain_count got %0d want 0", count); end
    endtask

    task automatic test_priority();
        set_in(1'b1, 5'd5, 32'hA5);
        tick();
        set_in(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd7, 32'h77);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (w_en !== 1'b1 || w_addr !== 5'd7 || count !== 3'd1) begin errors++; $display("FAIL prio_pipe%0d got %0h/%0h c%0d want 1/7 c1", i, w_en, w_addr, count); end
            tick();
        end
        set_pipe(1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (w_en !== 1'b1 || w_addr !== 5'd5 || w_din !== 32'hA5) begin errors++; $display("FAIL prio_queued got %0h/%0h/%0h want 1/5/a5", w_en, w_addr, w_din); end
        tick();
    endtask

    task automatic test_waw();
        set_pipe(1'b1, 5'd31, 32'd0);
        set_in(1'b1, 5'd3, 32'h1);
        tick();
        set_in(1'b1, 5'd3, 32'h2);
        tick();
        set_in(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd3, 32'h9);
        #1;
        checks++; if (w_addr !== 5'd3 || w_din !== 32'h9) begin errors++; $display("FAIL waw_pipe got %0h/%0h want 3/9", w_addr, w_din); end
        tick();
        set_pipe(1'b0, 5'd0, 32'd0);
        r1_addr = 5'd3;
        #1;
        checks++; if (r1_hit !== 1'b0) begin errors++; $display("FAIL waw_hit got %0h want 0", r1_hit); end
        checks++; if (w_en !== 1'b0 || count !== 3'd2) begin errors++; $display("FAIL waw_kill0 got %0h c%0d want 0 c2", w_en, count); end
        tick();
        checks++; if (w_en !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL waw_kill1 got %0h c%0d want 0 c1", w_en, count); end
        tick();
        r1_addr = 5'd0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL waw_empty got %0h want 1", empty); end
    endtask

    task automatic test_forward();
        set_pipe(1'b1, 5'd31, 32'd0);
        r1_addr = 5'd6;
        set_in(1'b1, 5'd6, 32'h10);
        #1;
        checks++; if (r1_hit !== 1'b0) begin errors++; $display("FAIL fwd_incoming got %0h want 0", r1_hit); end
        tick();
        set_in(1'b1, 5'd6, 32'h20);
        tick();
        set_in(1'b1, 5'd8, 32'h30);
        tick();
        set_in(1'b0, 5'd0, 32'd0);
        r2_addr = 5'd0;
        r3_addr = 5'd8;
        #1;
        checks++; if (r1_hit !== 1'b1 || r1_fwd !== 32'h20) begin errors++; $display("FAIL fwd_young got %0h/%0h want 1/20", r1_hit, r1_fwd); end
        checks++; if (r2_hit !== 1'b0 || r2_fwd !== 32'd0) begin errors++; $display("FAIL fwd_zero got %0h/%0h want 0/0", r2_hit, r2_fwd); end
        checks++; if (r3_hit !== 1'b1 || r3_fwd !== 32'h30) begin errors++; $display("FAIL fwd_r3 got %0h/%0h want 1/30", r3_hit, r3_fwd); end
        set_pipe(1'b0, 5'd0, 32'd0);
        r3_addr = 5'd0;
        for (int i = 0; i < 3; i++) tick();
        r1_addr = 5'd0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwd_drained got %0h want 1", empty); end
    endtask

    task automatic test_zero_wrap();
        logic [31:0] dq [10];
        set_in(1'b1, 5'd0, 32'hFF);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %0h want 1", in_ready); end
        tick();
        set_in(1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (count !== 3'd0 || w_en !== 1'b0) begin errors++; $display("FAIL zero_drop got c%0d w%0h want c0 w0", count, w_en); end
        for (int i = 0; i < 10; i++) begin
            dq[i] = $urandom;
            set_in(1'b1, 5'(i + 1), dq[i]);
            #1;
            if (i > 0) begin
                checks++; if (w_en !== 1'b1 || w_addr !== 5'(i) || w_din !== dq[i-1]) begin errors++; $display("FAIL wrap%0d got %0h/%0h/%0h want 1/%0h/%0h", i, w_en, w_addr, w_din, i, dq[i-1]); end
            end
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (w_addr !== 5'd10 || w_din !== dq[9]) begin errors++; $display("FAIL wrap_last got %0h/%0h want a/%0h", w_addr, w_din, dq[9]); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_pipe(1'b1, 5'd31, 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'(i + 12), 32'(i + 100));
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (w_en !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL rst_mid got w%0h c%0d e%0h want w0 c0 e1", w_en, count, empty); end
        mq.delete();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL rst_ghost%0d got %0h want 0", i, w_en); end
            tick();
        end
    endtask

    task automatic test_random();
        logic        e_en, h;
        logic [4:0]  e_a;
        logic [31:0] e_d, f;
        logic [4:0]  ra [3];
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
            set_pipe(($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom);
            r1_addr = 5'($urandom_range(0, 7));
            r2_addr = 5'($urandom_range(0, 7));
            r3_addr = 5'($urandom_range(0, 7));
            #1;
            if (pipe_wen && pipe_addr != 5'd0) begin
                e_en = 1'b1; e_a = pipe_addr; e_d = pipe_data;
            end else if (mq.size() > 0) begin
                e_en = mq[0].live; e_a = mq[0].a; e_d = mq[0].d;
            end else begin
                e_en = 1'b0; e_a = 5'd0; e_d = 32'd0;
            end
            checks++; if (w_en !== e_en || w_addr !== e_a || w_din !== e_d) begin errors++; $display("FAIL rand_write c%0d got %0h/%0h/%0h want %0h/%0h/%0h", c, w_en, w_addr, w_din, e_en, e_a, e_d); end
            checks++; if (count !== 3'(mq.size()) || in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rand_count c%0d got %0d/%0h want %0d", c, count, in_ready, mq.size()); end
            checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rand_flags c%0d got e%0h f%0h size %0d", c, empty, full, mq.size()); end
            ra[0] = r1_addr; ra[1] = r2_addr; ra[2] = r3_addr;
            lookup(ra[0], h, f);
            checks++; if (r1_hit !== h || r1_fwd !== f) begin errors++; $display("FAIL rand_r1 c%0d got %0h/%0h want %0h/%0h", c, r1_hit, r1_fwd, h, f); end
            lookup(ra[1], h, f);
            checks++; if (r2_hit !== h || r2_fwd !== f) begin errors++; $display("FAIL rand_r2 c%0d got %0h/%0h want %0h/%0h", c, r2_hit, r2_fwd, h, f); end
            lookup(ra[2], h, f);
            checks++; if (r3_hit !== h || r3_fwd !== f) begin errors++; $display("FAIL rand_r3 c%0d got %0h/%0h want %0h/%0h", c, r3_hit, r3_fwd, h, f); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        r1_addr = 5'd0;
        r2_addr = 5'd0;
        r3_addr = 5'd0;
        @(posedge clk);
        test_reset();
        test_fill_drain();
        test_priority();
        test_waw();
        test_forward();
        test_zero_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
